// File: rtl/pipeline_control.sv
// Pipeline stage-register load/flush control with stall, redirect and load-use
// handling, plus saturating performance counters.
module pipeline_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        hazard_load_use,
  input  logic        branch_taken,
  input  logic        perf_clear,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        flush_mem_wb,
  output logic [15:0] cnt_stall_i,
  output logic [15:0] cnt_stall_d,
  output logic [15:0] cnt_bubble,
  output logic [15:0] cnt_flush
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] LU_BUBBLE = 2'd1;
  localparam logic [1:0] IMISS     = 2'd2;
  localparam logic [1:0] DMISS     = 2'd3;

  logic [1:0] state, state_nxt;
  logic       istall, dstall;
  logic       inc_stall_i, inc_stall_d, inc_bubble, inc_flush;

  assign istall = imem_read & ~imem_resp;
  assign dstall = dmem_req & ~dmem_resp;

  // IMISS/DMISS only record the stall; on release the normal priority applies
  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    state_nxt    = RUN;
    inc_stall_i  = 1'b0;
    inc_stall_d  = 1'b0;
    inc_bubble   = 1'b0;
    inc_flush    = 1'b0;
    if (reset) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
    end else if (dstall) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      flush_mem_wb = 1'b1;
      state_nxt    = DMISS;
      inc_stall_d  = 1'b1;
    end else if (istall) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      inc_stall_i = 1'b1;
      state_nxt   = IMISS;
      if (branch_taken) begin
        // Hold the resolved branch in EX until the fetch returns
        load_id_ex   = 1'b0;
        flush_ex_mem = 1'b1;
      end else begin
        flush_id_ex = 1'b1;
      end
    end else if (branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      inc_flush   = 1'b1;
    end else if (hazard_load_use && state != LU_BUBBLE) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      flush_id_ex = 1'b1;
      state_nxt   = LU_BUBBLE;
      inc_bubble  = 1'b1;
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt_stall_i <= '0;
      cnt_stall_d <= '0;
      cnt_bubble  <= '0;
      cnt_flush   <= '0;
    end else begin
      state <= state_nxt;
      if (perf_clear) begin
        cnt_stall_i <= '0;
        cnt_stall_d <= '0;
        cnt_bubble  <= '0;
        cnt_flush   <= '0;
      end else begin
        cnt_stall_i <= sat_inc(cnt_stall_i, inc_stall_i);
        cnt_stall_d <= sat_inc(cnt_stall_d, inc_stall_d);
        cnt_bubble  <= sat_inc(cnt_bubble, inc_bubble);
        cnt_flush   <= sat_inc(cnt_flush, inc_flush);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed-vector bench for pipeline_control: control outputs per scenario
// and perf counter values against hand-computed expectations.
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_read, imem_resp, dmem_req, dmem_resp;
  logic        hazard_load_use, branch_taken, perf_clear;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [15:0] cnt_stall_i, cnt_stall_d, cnt_bubble, cnt_flush;

  int unsigned num_cmp = 0;
  int unsigned num_err = 0;

  pipeline_control dut (
    .clk(clk), .reset(reset),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .hazard_load_use(hazard_load_use), .branch_taken(branch_taken),
    .perf_clear(perf_clear),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .cnt_stall_i(cnt_stall_i), .cnt_stall_d(cnt_stall_d),
    .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  logic [4:0] lds;
  logic [3:0] fls;
  assign lds = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
  assign fls = {flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_cmp++;
    if (got !== exp) begin
      num_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [4:0] eld, input logic [3:0] efl);
    #1;
    check_val({tag, ".ld"}, {27'd0, lds}, {27'd0, eld});
    check_val({tag, ".fl"}, {28'd0, fls}, {28'd0, efl});
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] si, input logic [15:0] sd,
                           input logic [15:0] bu, input logic [15:0] fl);
    check_val({tag, ".si"}, {16'd0, cnt_stall_i}, {16'd0, si});
    check_val({tag, ".sd"}, {16'd0, cnt_stall_d}, {16'd0, sd});
    check_val({tag, ".bu"}, {16'd0, cnt_bubble}, {16'd0, bu});
    check_val({tag, ".fl"}, {16'd0, cnt_flush}, {16'd0, fl});
  endtask

  task automatic drive(input logic ir, input logic irs, input logic dr, input logic drs,
                       input logic hz, input logic br, input logic pc);
    imem_read = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs;
    hazard_load_use = hz; branch_taken = br; perf_clear = pc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_ctl("reset", 5'b11111, 4'b1111);
    step;
    reset = 1'b0;
    check_cnt("rst_cnt", 0, 0, 0, 0);
    check_ctl("advance", 5'b11111, 4'b0000);
    step;

    // Load-use held two cycles: bubble then masked
    drive(0, 0, 0, 0, 1, 0, 0);
    check_ctl("lu_c1", 5'b00111, 4'b0100);
    step;
    check_ctl("lu_c2", 5'b11111, 4'b0000);
    step;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("lu_cnt", 0, 0, 1, 0);

    // Branch overrides load-use
    drive(0, 0, 0, 0, 1, 1, 0);
    check_ctl("br_lu", 5'b11111, 4'b1100);
    step;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("br_cnt", 0, 0, 1, 1);

    // D-miss 3 cycles then response
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_ctl("dmiss", 5'b00001, 4'b0001);
      step;
    end
    drive(0, 0, 1, 1, 0, 0, 0);
    check_ctl("dmiss_rel", 5'b11111, 4'b0000);
    step;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("dmiss_cnt", 0, 3, 1, 1);

    // perf_clear zeroes everything
    drive(0, 0, 0, 0, 0, 1, 1);
    step;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("clear", 0, 0, 0, 0);

    // I-miss with branch held in EX, then response redirects
    drive(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      check_ctl("imiss_br", 5'b00011, 4'b0010);
      step;
    end
    drive(1, 1, 0, 0, 0, 1, 0);
    check_ctl("imiss_br_rel", 5'b11111, 4'b1100);
    step;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("imiss_br_cnt", 2, 0, 0, 1);

    // I-miss without branch
    drive(1, 0, 0, 0, 0, 0, 0);
    check_ctl("imiss", 5'b00111, 4'b0100);
    step;

    // D-miss on release with a load-use pending still inserts the bubble
    drive(0, 0, 1, 0, 1, 0, 0);
    check_ctl("both_hz_d", 5'b00001, 4'b0001);
    step;
    drive(0, 0, 1, 1, 1, 0, 0);
    check_ctl("drel_lu", 5'b00111, 4'b0100);
    step;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("mix_cnt", 3, 1, 1, 1);

    // Simultaneous I and D stall: DMISS behaviour only
    drive(1, 0, 1, 0, 0, 0, 0);
    check_ctl("both", 5'b00001, 4'b0001);
    step;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("both_cnt", 3, 2, 1, 1);

    // Reset during LU_BUBBLE returns to RUN: next load-use bubbles again
    drive(0, 0, 0, 0, 1, 0, 0);
    step;
    reset = 1'b1;
    check_ctl("rst_lu", 5'b11111, 4'b1111);
    step;
    reset = 1'b0;
    check_ctl("post_rst_lu", 5'b00111, 4'b0100);
    step;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset in DMISS
    drive(0, 0, 1, 0, 0, 0, 0);
    step;
    reset = 1'b1;
    check_ctl("rst_dmiss", 5'b11111, 4'b1111);
    step;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cnt("rst_dmiss_cnt", 0, 0, 0, 0);
    check_ctl("rst_dmiss_adv", 5'b11111, 4'b0000);

    // Saturation, then clear while stalling
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    check_val("sat", {16'd0, cnt_stall_d}, 32'h0000FFFF);
    drive(0, 0, 1, 0, 0, 0, 1);
    step;
    check_val("sat_clear", {16'd0, cnt_stall_d}, 32'd0);
    drive(0, 0, 1, 0, 0, 0, 0);
    step;
    check_val("post_clear", {16'd0, cnt_stall_d}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule
